// File: rtl/hr_inject_sched_pkg.sv
// Shared definitions for the ring injection scheduler: flit format, slot states, counter width.
package hr_inject_sched_pkg;

  localparam int unsigned FLIT_W    = 144;
  localparam int unsigned CONTROL_W = 16;
  localparam int unsigned CNT_W     = 8;

  localparam logic [FLIT_W-1:0] EMPTY_FLIT = '0;

  typedef struct packed {
    logic [CONTROL_W-1:0]        control;
    logic [FLIT_W-CONTROL_W-1:0] payload;
  } flit_t;

  typedef enum logic [1:0] {
    SLOT_IDLE   = 2'd0,
    SLOT_OFFER  = 2'd1,
    SLOT_STARVE = 2'd2
  } slot_state_e;

endpackage

// File: rtl/hr_slot_engine.sv
// One injection slot: round-robin capture of an eligible requester flit, hold until acked,
// and flag starvation when the offer waits STARVE_LIM cycles.
module hr_slot_engine
  import hr_inject_sched_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned STARVE_LIM = 16,
  parameter int unsigned SLOT       = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*FLIT_W-1:0] req_flit,
  input  logic [NREQ-1:0]        req_ring,
  input  logic                   ack,
  output logic [NREQ-1:0]        grant,
  output flit_t                  flit_o,
  output logic                   starve_o
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  slot_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] ptr;

  logic [NREQ-1:0]  elig;
  logic             found;
  logic [IDX_W-1:0] win;
  flit_t            win_flit;
  logic             take_c;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] & (req_ring[i] == 1'(SLOT));
    end
  end

  // Search starts one past the last winner and wraps once around all requesters.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!found && elig[IDX_W'((32'(ptr) + k) % NREQ)]) begin
        found = 1'b1;
        win   = IDX_W'((32'(ptr) + k) % NREQ);
      end
    end
  end

  assign win_flit = req_flit[FLIT_W*win +: FLIT_W];
  assign take_c   = found && ((state == SLOT_IDLE) || ack);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= SLOT_IDLE;
      cnt      <= '0;
      ptr      <= IDX_W'(NREQ - 1);
      grant    <= '0;
      flit_o   <= EMPTY_FLIT;
      starve_o <= 1'b0;
    end else begin
      grant <= '0;
      if (take_c) begin
        // An all-zero flit reads as empty on the port, so the slot stays free.
        grant    <= NREQ'(1) << win;
        ptr      <= win;
        flit_o   <= win_flit;
        cnt      <= '0;
        starve_o <= 1'b0;
        state    <= (win_flit == EMPTY_FLIT) ? SLOT_IDLE : SLOT_OFFER;
      end else if (state != SLOT_IDLE) begin
        if (ack) begin
          flit_o   <= EMPTY_FLIT;
          cnt      <= '0;
          starve_o <= 1'b0;
          state    <= SLOT_IDLE;
        end else if (cnt != LIM) begin
          cnt <= cnt + CNT_W'(1);
          if (cnt + CNT_W'(1) == LIM) begin
            state    <= SLOT_STARVE;
            starve_o <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/hr_inject_sched.sv
// Local-port injection scheduler: two independent slot engines feeding node local ports 0 and 1.
module hr_inject_sched
  import hr_inject_sched_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned STARVE_LIM = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*FLIT_W-1:0] req_flit,
  input  logic [NREQ-1:0]        req_ring,
  output logic [NREQ-1:0]        req_ready,
  output logic [FLIT_W-1:0]      port0_local_o,
  output logic [FLIT_W-1:0]      port1_local_o,
  input  logic                   portl0_ack,
  input  logic                   portl1_ack,
  output logic [1:0]             starve_o
);

  logic [NREQ-1:0] grant0;
  logic [NREQ-1:0] grant1;
  flit_t           flit0;
  flit_t           flit1;

  hr_slot_engine #(.NREQ(NREQ), .STARVE_LIM(STARVE_LIM), .SLOT(0)) u_slot0 (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_flit (req_flit),
    .req_ring (req_ring),
    .ack      (portl0_ack),
    .grant    (grant0),
    .flit_o   (flit0),
    .starve_o (starve_o[0])
  );

  hr_slot_engine #(.NREQ(NREQ), .STARVE_LIM(STARVE_LIM), .SLOT(1)) u_slot1 (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_flit (req_flit),
    .req_ring (req_ring),
    .ack      (portl1_ack),
    .grant    (grant1),
    .flit_o   (flit1),
    .starve_o (starve_o[1])
  );

  // Slots draw from disjoint requester sets, so merging their grant registers never collides.
  assign req_ready     = grant0 | grant1;
  assign port0_local_o = flit0;
  assign port1_local_o = flit1;

endmodule

// File: tb/tb_hr_inject_sched.sv
// Directed bench for hr_inject_sched with hand-computed expected values.
module tb_hr_inject_sched;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [575:0] req_flit;
  logic [3:0]   req_ring;
  logic [3:0]   req_ready;
  logic [143:0] port0_local_o;
  logic [143:0] port1_local_o;
  logic         portl0_ack;
  logic         portl1_ack;
  logic [1:0]   starve_o;

  logic [143:0] f [4];
  int checks;
  int errors;

  hr_inject_sched dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_flit     (req_flit),
    .req_ring     (req_ring),
    .req_ready    (req_ready),
    .port0_local_o(port0_local_o),
    .port1_local_o(port1_local_o),
    .portl0_ack   (portl0_ack),
    .portl1_ack   (portl1_ack),
    .starve_o     (starve_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) req_flit[144*i +: 144] = f[i];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    req_ring = '0;
    portl0_ack = 1'b0;
    portl1_ack = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++; if (port0_local_o !== '0) begin errors++; $display("FAIL reset_port0 got %h want 0", port0_local_o); end
    checks++; if (port1_local_o !== '0) begin errors++; $display("FAIL reset_port1 got %h want 0", port1_local_o); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    checks++; if (starve_o !== 2'b00) begin errors++; $display("FAIL reset_starve got %b want 00", starve_o); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001;
    req_ring = 4'b0000;
    step();
    checks++; if (port0_local_o !== f[0]) begin errors++; $display("FAIL single_port0 got %h want %h", port0_local_o, f[0]); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b want 0001", req_ready); end
    checks++; if (port1_local_o !== '0) begin errors++; $display("FAIL single_port1 got %h want 0", port1_local_o); end
    req_valid = 4'b0000;
    step();
    checks++; if (port0_local_o !== f[0]) begin errors++; $display("FAIL single_hold got %h want %h", port0_local_o, f[0]); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_pulse got %b want 0000", req_ready); end
    portl0_ack = 1'b1;
    step();
    checks++; if (port0_local_o !== '0) begin errors++; $display("FAIL single_clear got %h want 0", port0_local_o); end
    portl0_ack = 1'b0;
  endtask

  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    req_valid = 4'b1111;
    req_ring = 4'b0000;
    portl0_ack = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      checks++; if (req_ready !== 4'(1 << seq[n])) begin errors++; $display("FAIL rr_ready[%0d] got %b want %b", n, req_ready, 4'(1 << seq[n])); end
      checks++; if (port0_local_o !== f[seq[n]]) begin errors++; $display("FAIL rr_port0[%0d] got %h want %h", n, port0_local_o, f[seq[n]]); end
    end
    req_valid = 4'b0000;
    step();
    checks++; if (port0_local_o !== '0) begin errors++; $display("FAIL rr_drain got %h want 0", port0_local_o); end
    portl0_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    int s0 [4] = '{0, 2, 0, 2};
    int s1 [4] = '{1, 3, 1, 3};
    do_reset();
    req_valid = 4'b1111;
    req_ring = 4'b1010;
    portl0_ack = 1'b1;
    portl1_ack = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      checks++; if (req_ready !== 4'((1 << s0[n]) | (1 << s1[n]))) begin errors++; $display("FAIL b2b_ready[%0d] got %b want %b", n, req_ready, 4'((1 << s0[n]) | (1 << s1[n]))); end
      checks++; if (port0_local_o !== f[s0[n]]) begin errors++; $display("FAIL b2b_port0[%0d] got %h want %h", n, port0_local_o, f[s0[n]]); end
      checks++; if (port1_local_o !== f[s1[n]]) begin errors++; $display("FAIL b2b_port1[%0d] got %h want %h", n, port1_local_o, f[s1[n]]); end
    end
    req_valid = 4'b0000;
    portl0_ack = 1'b0;
    portl1_ack = 1'b0;
  endtask

  task automatic test_starve();
    do_reset();
    req_valid = 4'b0010;
    req_ring = 4'b0010;
    step();
    checks++; if (port1_local_o !== f[1]) begin errors++; $display("FAIL starve_offer got %h want %h", port1_local_o, f[1]); end
    req_valid = 4'b0000;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 15) begin
        checks++; if (starve_o !== 2'b00) begin errors++; $display("FAIL starve_early got %b want 00", starve_o); end
      end
      if (k >= 16) begin
        checks++; if (starve_o !== 2'b10) begin errors++; $display("FAIL starve_set[%0d] got %b want 10", k, starve_o); end
        checks++; if (port1_local_o !== f[1]) begin errors++; $display("FAIL starve_hold[%0d] got %h want %h", k, port1_local_o, f[1]); end
      end
    end
    req_valid = 4'b1000;
    req_ring = 4'b1000;
    portl1_ack = 1'b1;
    step();
    checks++; if (starve_o !== 2'b00) begin errors++; $display("FAIL starve_clear got %b want 00", starve_o); end
    checks++; if (port1_local_o !== f[3]) begin errors++; $display("FAIL starve_next got %h want %h", port1_local_o, f[3]); end
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL starve_ready got %b want 1000", req_ready); end
    req_valid = 4'b0000;
    step();
    checks++; if (port1_local_o !== '0) begin errors++; $display("FAIL starve_empty got %h want 0", port1_local_o); end
    portl1_ack = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    req_valid = 4'b0011;
    req_ring = 4'b0010;
    step();
    checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL ar_ready got %b want 0011", req_ready); end
    checks++; if (port1_local_o !== f[1]) begin errors++; $display("FAIL ar_port1 got %h want %h", port1_local_o, f[1]); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (port0_local_o !== '0) begin errors++; $display("FAIL ar_port0_clr got %h want 0", port0_local_o); end
    checks++; if (port1_local_o !== '0) begin errors++; $display("FAIL ar_port1_clr got %h want 0", port1_local_o); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL ar_ready_clr got %b want 0000", req_ready); end
    req_valid = 4'b1111;
    req_ring = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    step();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ar_first_ready got %b want 0001", req_ready); end
    checks++; if (port0_local_o !== f[0]) begin errors++; $display("FAIL ar_first_port0 got %h want %h", port0_local_o, f[0]); end
    req_valid = 4'b0000;
  endtask

  task automatic test_idle_ack();
    do_reset();
    portl0_ack = 1'b1;
    portl1_ack = 1'b1;
    step();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL idle_ack_ready got %b want 0000", req_ready); end
    checks++; if ({port0_local_o, port1_local_o} !== '0) begin errors++; $display("FAIL idle_ack_ports got %h %h want 0", port0_local_o, port1_local_o); end
    req_valid = 4'b0001;
    #2;
    req_valid = 4'b0000;
    step();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL drop_ready got %b want 0000", req_ready); end
    checks++; if (port0_local_o !== '0) begin errors++; $display("FAIL drop_port0 got %h want 0", port0_local_o); end
    portl0_ack = 1'b0;
    portl1_ack = 1'b0;
  endtask

  task automatic test_zero_flit();
    logic [143:0] saved;
    saved = f[0];
    f[0] = '0;
    do_reset();
    req_valid = 4'b0001;
    req_ring = 4'b0000;
    step();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL zero_ready got %b want 0001", req_ready); end
    checks++; if (port0_local_o !== '0) begin errors++; $display("FAIL zero_port0 got %h want 0", port0_local_o); end
    req_valid = 4'b0010;
    step();
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL zero_next_ready got %b want 0010", req_ready); end
    checks++; if (port0_local_o !== f[1]) begin errors++; $display("FAIL zero_next_port0 got %h want %h", port0_local_o, f[1]); end
    req_valid = 4'b0000;
    f[0] = saved;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 4; i++) f[i] = (144'(i + 1) << 128) | 144'(32'h1855 + 32'(i));
    rst = 1'b0;
    req_valid = '0;
    req_ring = '0;
    portl0_ack = 1'b0;
    portl1_ack = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_starve();
    test_async_reset();
    test_idle_ack();
    test_zero_flit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
